// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event arbiter.
package btn_evt_pkg;

    // Hold and repeat counter width
    localparam int unsigned CNT_W = 16;

    // Event type codes as seen on the event port
    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_SHORT  = 2'b01,
        EVT_LONG   = 2'b10,
        EVT_REPEAT = 2'b11
    } evt_type_e;

    // Per-button press classifier states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } fsm_state_e;

endpackage

// File: rtl/btn_press_fsm.sv
// Per-button press classifier: turns a debounced level plus the ms tick
// into SHORT / LONG / REPEAT strobes. The strobe is combinational so the
// top-level pending slot captures it on the same edge the FSM advances.
module btn_press_fsm
    import btn_evt_pkg::*;
#(
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      level,
    input  logic      ms_tick,
    output logic      evt_stb,
    output evt_type_e evt_type
);

    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] REP_CNT  = CNT_W'(REPEAT_MS);

    fsm_state_e       state;
    fsm_state_e       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_nxt;
    logic [CNT_W-1:0] hold_inc;
    logic [CNT_W-1:0] rep_inc;
    logic             level_q;

    assign hold_inc = hold_cnt + CNT_W'(1);
    assign rep_inc  = rep_cnt + CNT_W'(1);

    // State, counters and previous level; level_q resets high so a button
    // still held when reset drops is not mistaken for a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            level_q  <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            rep_cnt  <= rep_cnt_nxt;
            level_q  <= level;
        end
    end

    // Next-state and event decode; a release beats a same-cycle long tick.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        rep_cnt_nxt  = rep_cnt;
        evt_stb      = 1'b0;
        evt_type     = EVT_NONE;
        unique case (state)
            ST_IDLE: begin
                if (level && !level_q) begin
                    hold_cnt_nxt = '0;
                    state_nxt    = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!level) begin
                    evt_stb   = 1'b1;
                    evt_type  = EVT_SHORT;
                    state_nxt = ST_IDLE;
                end else if (ms_tick) begin
                    hold_cnt_nxt = hold_inc;
                    if (hold_inc == LONG_CNT) begin
                        evt_stb     = 1'b1;
                        evt_type    = EVT_LONG;
                        rep_cnt_nxt = '0;
                        state_nxt   = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (!level) begin
                    state_nxt = ST_IDLE;
                end else if (ms_tick) begin
                    if (rep_inc == REP_CNT) begin
                        evt_stb     = 1'b1;
                        evt_type    = EVT_REPEAT;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_inc;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Classifies button presses and serializes the resulting events onto one
// valid/ready port via per-button pending slots and a round-robin arbiter.
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN     = 4,
    parameter int unsigned MS_DIV    = 1000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_tick,
    input  logic [N_BTN-1:0]         i_btn_level,
    output logic                     o_evt_valid,
    output logic [$clog2(N_BTN)-1:0] o_evt_id,
    output logic [1:0]               o_evt_type,
    input  logic                     i_evt_ready,
    output logic [N_BTN-1:0]         o_ovf,
    input  logic                     i_ovf_clr
);

    localparam int unsigned ID_W  = $clog2(N_BTN);
    localparam int unsigned SUM_W = ID_W + 1;
    localparam int unsigned PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             ms_tick;

    logic [N_BTN-1:0] fsm_stb;
    evt_type_e        fsm_type [N_BTN];

    logic [N_BTN-1:0] slot_vld;
    evt_type_e        slot_typ [N_BTN];
    logic [ID_W-1:0]  rr_ptr;

    logic             load_c;
    logic             gnt_found_c;
    logic [ID_W-1:0]  gnt_idx_c;
    logic [ID_W-1:0]  gnt_nxt_c;
    logic [N_BTN-1:0] gnt_oh_c;
    logic [N_BTN-1:0] slot_clr_c;
    logic [N_BTN-1:0] ovf_set_c;

    // Millisecond prescaler: one ms_tick per MS_DIV input strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            ms_tick <= 1'b0;
        end else begin
            ms_tick <= 1'b0;
            if (i_tick) begin
                if (pre_cnt == PRE_LAST) begin
                    pre_cnt <= '0;
                    ms_tick <= 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_press_fsm #(
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS)
        ) u_fsm (
            .clk      (clk),
            .rst      (rst),
            .level    (i_btn_level[g]),
            .ms_tick  (ms_tick),
            .evt_stb  (fsm_stb[g]),
            .evt_type (fsm_type[g])
        );
    end

    // Round-robin search for the first pending slot at or after rr_ptr
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] nxt;
        logic [ID_W-1:0]  idx;
        sum         = '0;
        nxt         = '0;
        idx         = '0;
        load_c      = !o_evt_valid || i_evt_ready;
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        gnt_oh_c    = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (sum >= SUM_W'(N_BTN)) begin
                sum = sum - SUM_W'(N_BTN);
            end
            idx = ID_W'(sum);
            if (!gnt_found_c && slot_vld[idx]) begin
                gnt_found_c   = 1'b1;
                gnt_idx_c     = idx;
                gnt_oh_c[idx] = 1'b1;
            end
        end
        nxt = {1'b0, gnt_idx_c} + SUM_W'(1);
        if (nxt == SUM_W'(N_BTN)) begin
            nxt = '0;
        end
        gnt_nxt_c  = ID_W'(nxt);
        slot_clr_c = gnt_oh_c & {N_BTN{load_c}};
        ovf_set_c  = fsm_stb & slot_vld & ~slot_clr_c;
    end

    // Pending slots: accept a new event when empty or drained this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                slot_typ[i] <= EVT_NONE;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (fsm_stb[i] && (!slot_vld[i] || slot_clr_c[i])) begin
                    slot_vld[i] <= 1'b1;
                    slot_typ[i] <= fsm_type[i];
                end else if (slot_clr_c[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flags; a new overflow outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ovf <= '0;
        end else begin
            o_ovf <= (i_ovf_clr ? '0 : o_ovf) | ovf_set_c;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_evt_valid <= 1'b0;
            o_evt_id    <= '0;
            o_evt_type  <= 2'b00;
            rr_ptr      <= '0;
        end else if (load_c) begin
            if (gnt_found_c) begin
                o_evt_valid <= 1'b1;
                o_evt_id    <= gnt_idx_c;
                o_evt_type  <= slot_typ[gnt_idx_c];
                rr_ptr      <= gnt_nxt_c;
            end else begin
                o_evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with MS_DIV=2, LONG_MS=5, REPEAT_MS=3.
module tb_btn_event_arbiter;

    localparam int unsigned N_BTN     = 4;
    localparam int unsigned MS_DIV    = 2;
    localparam int unsigned LONG_MS   = 5;
    localparam int unsigned REPEAT_MS = 3;
    localparam int T_S = 1;
    localparam int T_L = 2;
    localparam int T_R = 3;
    localparam int N_VEC = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_tick = 1'b0;
    logic [3:0] i_btn_level = 4'b0000;
    logic       o_evt_valid;
    logic [1:0] o_evt_id;
    logic [1:0] o_evt_type;
    logic       i_evt_ready = 1'b1;
    logic [3:0] o_ovf;
    logic       i_ovf_clr = 1'b0;

    btn_event_arbiter #(
        .N_BTN     (N_BTN),
        .MS_DIV    (MS_DIV),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_btn_level (i_btn_level),
        .o_evt_valid (o_evt_valid),
        .o_evt_id    (o_evt_id),
        .o_evt_type  (o_evt_type),
        .i_evt_ready (i_evt_ready),
        .o_ovf       (o_ovf),
        .i_ovf_clr   (i_ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      mask;
        logic [7:0]      hold;
        logic [1:0]      n_ev;
        logic [2:0][1:0] id;
        logic [2:0][1:0] typ;
        logic [2:0][7:0] ms;
        logic            b2b;
    } vec_t;

    typedef struct packed {
        int id;
        int typ;
        int stamp;
        int cyc;
    } ev_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   wraps = 0;
    int   pre = 0;
    int   tick_ph = 0;
    int   cyc = 0;
    int   press_ms = 0;
    ev_t  log_q[$];
    vec_t vec[N_VEC];

    // Free-running 1 us strobe (every 4th cycle) and a count of ms wraps
    always @(posedge clk) begin
        if (rst) begin
            pre = 0;
        end else if (i_tick) begin
            if (pre == int'(MS_DIV) - 1) begin
                pre = 0;
                wraps++;
            end else begin
                pre++;
            end
        end
        tick_ph = (tick_ph + 1) % 4;
        #1 i_tick = (tick_ph == 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; sample #1 after the edge and log any accepted event
    task automatic step();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (o_evt_valid && i_evt_ready) begin
            e.id    = int'(o_evt_id);
            e.typ   = int'(o_evt_type);
            e.stamp = wraps - press_ms;
            e.cyc   = cyc;
            log_q.push_back(e);
        end
    endtask

    task automatic wait_ms(input int n);
        int guard;
        guard = 0;
        while ((wraps - press_ms) < n && guard < 8 * n + 32) begin
            step();
            guard++;
        end
        if ((wraps - press_ms) < n) chk("ms wait timeout", wraps - press_ms, n);
    endtask

    task automatic run_press(input logic [3:0] mask, input int hold);
        i_btn_level = i_btn_level | mask;
        press_ms = wraps;
        wait_ms(hold);
        i_btn_level = i_btn_level & ~mask;
        repeat (12) step();
    endtask

    function automatic vec_t mk(input logic [3:0] mask, input int hold, input int n,
                                input logic b2b,
                                input int id0, input int t0, input int m0,
                                input int id1, input int t1, input int m1,
                                input int id2, input int t2, input int m2);
        vec_t v;
        v        = '0;
        v.mask   = mask;
        v.hold   = 8'(hold);
        v.n_ev   = 2'(n);
        v.b2b    = b2b;
        v.id[0]  = 2'(id0);
        v.typ[0] = 2'(t0);
        v.ms[0]  = 8'(m0);
        v.id[1]  = 2'(id1);
        v.typ[1] = 2'(t1);
        v.ms[1]  = 8'(m1);
        v.id[2]  = 2'(id2);
        v.typ[2] = 2'(t2);
        v.ms[2]  = 8'(m2);
        return v;
    endfunction

    initial begin
        int  guard;
        bit  checked10;

        // mask, hold_ms, n_events, back-to-back, {id, type, ms-after-press} x3
        vec[0] = mk(4'b0001,  3, 1, 1'b0, 0, T_S, 3,  0, 0, 0,   0, 0, 0);
        vec[1] = mk(4'b0001,  5, 1, 1'b0, 0, T_S, 5,  0, 0, 0,   0, 0, 0);
        vec[2] = mk(4'b0010, 12, 3, 1'b0, 1, T_L, 5,  1, T_R, 8, 1, T_R, 11);
        vec[3] = mk(4'b1000,  1, 1, 1'b0, 3, T_S, 1,  0, 0, 0,   0, 0, 0);
        vec[4] = mk(4'b1101,  2, 3, 1'b1, 0, T_S, 2,  2, T_S, 2, 3, T_S, 2);
        vec[5] = mk(4'b0100,  2, 1, 1'b0, 2, T_S, 2,  0, 0, 0,   0, 0, 0);
        vec[6] = mk(4'b1101,  2, 3, 1'b1, 3, T_S, 2,  0, T_S, 2, 2, T_S, 2);

        // Asynchronous reset values before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset valid", int'(o_evt_valid), 0);
        chk("reset id", int'(o_evt_id), 0);
        chk("reset type", int'(o_evt_type), 0);
        chk("reset ovf", int'(o_ovf), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (4) step();

        // Table of press scenarios with ready held high
        for (int v = 0; v < N_VEC; v++) begin
            log_q.delete();
            run_press(vec[v].mask, int'(vec[v].hold));
            chk($sformatf("v%0d count", v), log_q.size(), int'(vec[v].n_ev));
            for (int e = 0; e < int'(vec[v].n_ev); e++) begin
                if (e < log_q.size()) begin
                    chk($sformatf("v%0d ev%0d id", v, e), log_q[e].id, int'(vec[v].id[2'(e)]));
                    chk($sformatf("v%0d ev%0d type", v, e), log_q[e].typ, int'(vec[v].typ[2'(e)]));
                    chk($sformatf("v%0d ev%0d ms", v, e), log_q[e].stamp, int'(vec[v].ms[2'(e)]));
                    if (vec[v].b2b && e > 0) begin
                        chk($sformatf("v%0d ev%0d spacing", v, e), log_q[e].cyc - log_q[e-1].cyc, 1);
                    end
                end
            end
            chk($sformatf("v%0d ovf", v), int'(o_ovf), 0);
        end

        // Backpressure: LONG held in the output, first REPEAT in the slot, second overflows
        i_evt_ready = 1'b0;
        step();
        i_btn_level[1] = 1'b1;
        press_ms = wraps;
        guard = 0;
        checked10 = 1'b0;
        while ((wraps - press_ms) < 12 && guard < 200) begin
            step();
            guard++;
            if (o_evt_valid) begin
                chk("bp id stable", int'(o_evt_id), 1);
                chk("bp type stable", int'(o_evt_type), T_L);
            end
            if ((wraps - press_ms) == 10 && !checked10) begin
                checked10 = 1'b1;
                chk("bp ovf before 2nd repeat", int'(o_ovf), 0);
                chk("bp valid held", int'(o_evt_valid), 1);
            end
        end
        if ((wraps - press_ms) < 12) chk("bp hold timeout", wraps - press_ms, 12);
        i_btn_level[1] = 1'b0;
        chk("bp ovf set", int'(o_ovf), 4'b0010);
        repeat (3) step();
        chk("bp valid after release", int'(o_evt_valid), 1);
        chk("bp type after release", int'(o_evt_type), T_L);
        i_evt_ready = 1'b1;
        step();
        chk("bp 2nd valid", int'(o_evt_valid), 1);
        chk("bp 2nd id", int'(o_evt_id), 1);
        chk("bp 2nd type", int'(o_evt_type), T_R);
        step();
        chk("bp drained", int'(o_evt_valid), 0);
        repeat (4) step();
        chk("bp stays empty", int'(o_evt_valid), 0);
        chk("bp ovf sticky", int'(o_ovf), 4'b0010);
        i_ovf_clr = 1'b1;
        step();
        i_ovf_clr = 1'b0;
        chk("bp ovf cleared", int'(o_ovf), 0);

        // Reset in the middle of a hold with an event parked in the output
        i_evt_ready = 1'b0;
        i_btn_level[0] = 1'b1;
        press_ms = wraps;
        wait_ms(1);
        i_btn_level[0] = 1'b0;
        repeat (4) step();
        chk("rs parked valid", int'(o_evt_valid), 1);
        chk("rs parked type", int'(o_evt_type), T_S);
        i_btn_level[2] = 1'b1;
        press_ms = wraps;
        wait_ms(3);
        #3 rst = 1'b1;
        #1;
        chk("rs async valid", int'(o_evt_valid), 0);
        chk("rs async id", int'(o_evt_id), 0);
        chk("rs async type", int'(o_evt_type), 0);
        chk("rs async ovf", int'(o_ovf), 0);
        repeat (2) @(posedge clk);
        #1 chk("rs held valid", int'(o_evt_valid), 0);
        @(negedge clk) rst = 1'b0;
        i_evt_ready = 1'b1;
        log_q.delete();
        repeat (48) step();
        chk("rs no event while held", log_q.size(), 0);
        i_btn_level[2] = 1'b0;
        repeat (12) step();
        chk("rs no event on release", log_q.size(), 0);
        run_press(4'b0100, 1);
        chk("rs new press count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("rs new press id", log_q[0].id, 2);
            chk("rs new press type", log_q[0].typ, T_S);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
